alu_seq: RTL
============

Name: alu_seq

Overview:
- Command sequencer that sits directly upstream of the 4-function ALU (modes: 00 A+B, 01 A*B, 10 A-1, 11 B).
- Accepts one operation per valid/ready handshake and registers the operands and mode onto the ALU inputs.
- Waits a programmable settle time, then captures the ALU's 16-bit result and presents it downstream with its own valid/ready handshake.
- Supports chaining: the low byte of the previous result can be used as operand A.

Parameters:
- WIDTH, 8, operand width; the ALU result is 2*WIDTH bits.
- LAT, 1, number of clock cycles the ALU inputs are held stable before the result is captured. Legal range 1..15.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  sequencer can accept a command.
- i_cmd_A  input  WIDTH  operand A.
- i_cmd_B  input  WIDTH  operand B.
- i_cmd_mode  input  2  ALU mode.
- i_cmd_chain  input  1  1 = use last_res[WIDTH-1:0] as A and ignore i_cmd_A.
- o_alu_A  output  WIDTH  registered operand A to the ALU.
- o_alu_B  output  WIDTH  registered operand B to the ALU.
- o_alu_mode  output  2  registered mode to the ALU.
- i_alu_out  input  2*WIDTH  ALU result (combinational from o_alu_*).
- o_res_valid  output  1  result available.
- i_res_ready  input  1  consumer accepts the result.
- o_res  output  2*WIDTH  captured result.
- o_ovf  output  1  high when o_res[2*WIDTH-1:WIDTH] != 0.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE.
  - o_alu_A, o_alu_B, o_alu_mode, o_res, o_ovf, o_res_valid, o_busy and the internal last_res all clear to 0.
  - o_cmd_ready=1 once reset is released.
  - Reset asserted mid-operation aborts the operation: no result is produced and last_res is cleared.
- FSM states:
  - IDLE: o_cmd_ready=1. When i_cmd_valid is high at a rising edge (accept edge E0):
    - o_alu_A is loaded with i_cmd_chain ? last_res[WIDTH-1:0] : i_cmd_A.
    - o_alu_B is loaded with i_cmd_B and o_alu_mode with i_cmd_mode.
    - The counter is loaded with LAT-1 and the FSM moves to EXEC.
  - EXEC: o_cmd_ready=0 and o_busy=1. The counter decrements each cycle. At the edge where the counter equals 0 (edge E0+LAT):
    - o_res and last_res take i_alu_out.
    - o_ovf takes the upper-half check of i_alu_out.
    - The FSM moves to DONE.
  - DONE: o_res_valid=1 and o_cmd_ready=0. o_res and o_ovf are held stable. At an edge with i_res_ready=1, o_res_valid drops and the FSM moves to IDLE.
- Latency:
  - o_res_valid is first high in the cycle following edge E0+LAT.
  - With i_res_ready tied high, back-to-back throughput is one command per LAT+2 cycles.
- o_alu_A, o_alu_B and o_alu_mode change only at an accept edge. They hold their values through DONE and IDLE.
- Commands are never accepted in EXEC or DONE. i_cmd_valid during those states is ignored, and the command is held by the upstream until ready.
- A chained command uses last_res as captured by the most recent completed operation. After reset last_res=0, so a chain command yields A=0.
- Width rules: the result is captured unmodified. o_ovf covers:
  - A+B carry;
  - a product exceeding 8 bits;
  - A-1 with A=0, which gives 16'hFFFF.
- Unknown or X modes need no special handling; they pass through to the ALU.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0. After release, o_cmd_ready=1 and o_busy=0.
- LAT=2, command A=8'hFF B=8'hFF mode=01 accepted at edge E0 -> o_res_valid rises after edge E0+2 with o_res=16'hFE01, o_ovf=1. With i_res_ready=1 it drops one cycle later and o_cmd_ready returns to 1.
- Chain: command A=8'h80 B=8'h85 mode=00 -> o_res=16'h0105, o_ovf=1. Then chain=1, i_cmd_A=8'hAA, B=8'h03, mode=00 -> o_alu_A=8'h05, o_res=16'h0008, o_ovf=0.
- Underflow and pass-through:
  - A=8'h00 mode=10 -> o_res=16'hFFFF, o_ovf=1.
  - A=8'h12 B=8'h34 mode=11 -> o_res=16'h0034, o_ovf=0.
- Backpressure: hold i_res_ready=0 for 5 cycles while toggling i_cmd_valid with new operands -> o_res_valid stays 1, o_res is unchanged, o_cmd_ready stays 0 and o_alu_* are unchanged. Releasing i_res_ready completes the handshake.
- Reset mid-operation: assert i_rst_n=0 in the first EXEC cycle -> o_res_valid never rises, outputs clear immediately (asynchronously), and the next chain command uses A=0.

Source files
------------

// File: rtl/alu_seq.sv
//==============================================================================
// Module      : alu_seq
// Description : Command sequencer for the 4-function ALU. It registers the
//               operands onto the ALU, waits LAT cycles, then captures and
//               presents the result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [WIDTH-1:0]     i_cmd_A,
    input  logic [WIDTH-1:0]     i_cmd_B,
    input  logic [1:0]           i_cmd_mode,
    input  logic                 i_cmd_chain,
    output logic [WIDTH-1:0]     o_alu_A,
    output logic [WIDTH-1:0]     o_alu_B,
    output logic [1:0]           o_alu_mode,
    input  logic [2*WIDTH-1:0]   i_alu_out,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [2*WIDTH-1:0]   o_res,
    output logic                 o_ovf,
    output logic                 o_busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // LAT is limited to 1..15, so a 4-bit down-counter is enough.
    localparam logic [3:0] c_cnt_init = 4'(LAT - 1);

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [1:0]         r_alu_mode;
    logic [2*WIDTH-1:0] r_res;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_last_lo;

    logic               w_accept;
    logic               w_ovf;

    assign w_accept = (r_state == c_st_idle) && i_cmd_valid;
    assign w_ovf    = |i_alu_out[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= 4'd0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_mode <= 2'b00;
            r_res      <= '0;
            r_ovf      <= 1'b0;
            r_last_lo  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_alu_a    <= i_cmd_chain ? r_last_lo : i_cmd_A;
                        r_alu_b    <= i_cmd_B;
                        r_alu_mode <= i_cmd_mode;
                        r_cnt      <= c_cnt_init;
                        r_state    <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    if (r_cnt == 4'd0) begin
                        r_res     <= i_alu_out;
                        r_ovf     <= w_ovf;
                        // Only the low half is ever reused as a chained operand.
                        r_last_lo <= i_alu_out[WIDTH-1:0];
                        r_state   <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_done: begin
                    if (i_res_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Status outputs are straight decodes of the state register.
    assign o_cmd_ready = (r_state == c_st_idle);
    assign o_busy      = (r_state != c_st_idle);
    assign o_res_valid = (r_state == c_st_done);
    assign o_alu_A     = r_alu_a;
    assign o_alu_B     = r_alu_b;
    assign o_alu_mode  = r_alu_mode;
    assign o_res       = r_res;
    assign o_ovf       = r_ovf;

endmodule

`default_nettype wire
